// File: rtl/seven_segment_scan_driver_if.sv
// Bus between a value/MMIO source and the seven-segment scan driver.
// The master supplies the value to show and its controls; the slave
// (the scan driver) returns the pending flag and the pin-level outputs.
interface seven_segment_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] io_value;
  logic [NUM_DIGITS-1:0]   io_dp;
  logic                    io_load;
  logic                    io_enable;
  logic                    io_pending;
  logic [6:0]              io_segOut;
  logic                    io_dpOut;
  logic [NUM_DIGITS-1:0]   io_anode;

  modport master (
    output io_value, io_dp, io_load, io_enable,
    input  io_pending, io_segOut, io_dpOut, io_anode
  );

  modport slave (
    input  io_value, io_dp, io_load, io_enable,
    output io_pending, io_segOut, io_dpOut, io_anode
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed hex driver for a multi-digit seven-segment display.
// A prescaler sets how long each digit stays selected; digits are scanned
// round-robin. New values land in a shadow register and are only copied to
// the displayed (active) register at the end of a frame, so a single frame
// never shows a mix of old and new digits.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_AN  = 0,
  parameter int LZ_BLANK       = 1
) (
  input logic clock,
  input logic reset,
  seven_segment_scan_driver_if.slave bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // XOR masks that turn a logical (active-high) pattern into pin polarity;
  // they are also the idle pin levels.
  localparam logic [6:0]            SEG_MASK = {7{ACTIVE_LOW_SEG != 0}};
  localparam logic                  DP_MASK  = (ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{ACTIVE_LOW_AN != 0}};

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digitIdx;
  logic [4*NUM_DIGITS-1:0] shadowValue;
  logic [NUM_DIGITS-1:0]   shadowDp;
  logic [4*NUM_DIGITS-1:0] activeValue;
  logic [NUM_DIGITS-1:0]   activeDp;
  logic                    pendingReg;
  logic [6:0]              segReg;
  logic                    dpReg;
  logic [NUM_DIGITS-1:0]   anodeReg;

  logic                    prescalerWrap;
  logic                    lastDigit;
  logic                    frameEnd;
  logic [4*NUM_DIGITS-1:0] shiftedValue;
  logic                    blankDigit;
  logic [6:0]              segLogical;
  logic                    dpLogical;
  logic [NUM_DIGITS-1:0]   anodeLogical;

  // Hex nibble to {a,b,c,d,e,f,g} with a in bit 6; lowercase b and d so
  // they are distinguishable from 8 and 0.
  function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
    case (nibble)
      4'h0:    decodeHex = 7'h7E;
      4'h1:    decodeHex = 7'h30;
      4'h2:    decodeHex = 7'h6D;
      4'h3:    decodeHex = 7'h79;
      4'h4:    decodeHex = 7'h33;
      4'h5:    decodeHex = 7'h5B;
      4'h6:    decodeHex = 7'h5F;
      4'h7:    decodeHex = 7'h70;
      4'h8:    decodeHex = 7'h7F;
      4'h9:    decodeHex = 7'h7B;
      4'hA:    decodeHex = 7'h77;
      4'hB:    decodeHex = 7'h1F;
      4'hC:    decodeHex = 7'h4E;
      4'hD:    decodeHex = 7'h3D;
      4'hE:    decodeHex = 7'h4F;
      default: decodeHex = 7'h47;
    endcase
  endfunction

  assign prescalerWrap = (prescaler == PRE_W'(REFRESH_DIV - 1));
  assign lastDigit     = (digitIdx == IDX_W'(NUM_DIGITS - 1));
  assign frameEnd      = prescalerWrap && lastDigit;

  // Work out what the currently scanned digit should show. Shifting the
  // active value down by the digit index puts that digit's nibble at the
  // bottom and leaves only the more significant nibbles above it, so an
  // all-zero result means this digit is a leading zero.
  always_comb begin
    shiftedValue = activeValue >> {digitIdx, 2'b00};
    blankDigit   = (LZ_BLANK != 0) && (digitIdx != '0) && (shiftedValue == '0);
    segLogical   = blankDigit ? 7'h00 : decodeHex(shiftedValue[3:0]);
    dpLogical    = activeDp[digitIdx];
    anodeLogical = '0;
    if (bus.io_enable && (prescaler != '0)) begin
      anodeLogical = NUM_DIGITS'(1) << digitIdx;
    end
  end

  // Scan timing: the prescaler paces each digit slot and the digit index
  // advances round-robin every time the prescaler wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digitIdx  <= '0;
    end else begin
      if (prescalerWrap) begin
        prescaler <= '0;
        digitIdx  <= lastDigit ? '0 : digitIdx + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // Shadow capture and frame-end commit. A load on the frame-end cycle
  // still commits the previous shadow and keeps pending set for the value
  // that just arrived.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadowValue <= '0;
      shadowDp    <= '0;
      activeValue <= '0;
      activeDp    <= '0;
      pendingReg  <= 1'b0;
    end else begin
      if (frameEnd && pendingReg) begin
        activeValue <= shadowValue;
        activeDp    <= shadowDp;
        pendingReg  <= 1'b0;
      end
      if (bus.io_load) begin
        shadowValue <= bus.io_value;
        shadowDp    <= bus.io_dp;
        pendingReg  <= 1'b1;
      end
    end
  end

  // Register the pin outputs with polarity applied so the pins never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segReg   <= SEG_MASK;
      dpReg    <= DP_MASK;
      anodeReg <= AN_MASK;
    end else begin
      segReg   <= segLogical ^ SEG_MASK;
      dpReg    <= dpLogical ^ DP_MASK;
      anodeReg <= anodeLogical ^ AN_MASK;
    end
  end

  assign bus.io_pending = pendingReg;
  assign bus.io_segOut  = segReg;
  assign bus.io_dpOut   = dpReg;
  assign bus.io_anode   = anodeReg;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for the seven-segment scan driver: a 4-digit, divide-by-4 instance
// with active-high pins, plus an active-low instance for the polarity and
// enable cases. Expected frames come from a segment table and frame timing.
module tb_seven_segment_scan_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [6:0] segTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct {
    int         cycle;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } sbEntry_t;

  sbEntry_t sbQueue [$];
  sbEntry_t sbFront;

  seven_segment_scan_driver_if #(.NUM_DIGITS(4)) mainIf ();
  seven_segment_scan_driver_if #(.NUM_DIGITS(4)) invIf ();

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0), .LZ_BLANK(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(mainIf)
  );

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1), .LZ_BLANK(1)
  ) dutInv (
    .clock(clock),
    .reset(reset),
    .bus(invIf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Count active edges since reset release; frame timing is derived from it.
  always @(posedge clock or posedge reset) begin
    if (reset) cycle <= 0;
    else       cycle <= cycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", tag, cycle, actual, expected);
    end
  endtask

  // Pulse a one-cycle load on the main instance; returns one negedge later.
  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp);
    mainIf.io_value = value;
    mainIf.io_dp    = dp;
    mainIf.io_load  = 1'b1;
    @(negedge clock);
    mainIf.io_load  = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cycle < target) @(negedge clock);
  endtask

  // Queue the 16 expected output slots of a frame. Frame f covers scan
  // states 16f..16f+15, and each state shows up on the pins one edge later.
  task automatic pushFrame(input int frame, input logic [15:0] value, input logic [3:0] dp);
    for (int n = 16 * frame; n < 16 * frame + 16; n++) begin
      sbEntry_t   e;
      int         p;
      int         i;
      logic [15:0] upper;
      p       = n % 4;
      i       = (n / 4) % 4;
      upper   = value >> (4 * i);
      e.cycle = n + 1;
      e.seg   = ((i != 0) && (upper == 16'h0)) ? 7'h00 : segTable[upper[3:0]];
      e.anode = (p == 0) ? 4'b0000 : 4'(1 << i);
      e.dp    = dp[i];
      sbQueue.push_back(e);
    end
  endtask

  // Scoreboard monitor: compare every queued slot on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      while (sbQueue.size() > 0 && sbQueue[0].cycle <= cycle) begin
        sbFront = sbQueue.pop_front();
        if (sbFront.cycle != cycle) checkOutput("sbStale", sbFront.cycle, cycle);
        checkOutput("sbAnode", 32'(mainIf.io_anode), 32'(sbFront.anode));
        checkOutput("sbSeg",   32'(mainIf.io_segOut), 32'(sbFront.seg));
        checkOutput("sbDp",    32'(mainIf.io_dpOut), 32'(sbFront.dp));
      end
    end
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mainIf.io_value  = '0;
    mainIf.io_dp     = '0;
    mainIf.io_load   = 1'b0;
    mainIf.io_enable = 1'b1;
    invIf.io_value   = '0;
    invIf.io_dp      = '0;
    invIf.io_load    = 1'b0;
    invIf.io_enable  = 1'b1;

    // Reset levels, including inverted pins on the active-low instance.
    #8;
    checkOutput("rstAnode",    32'(mainIf.io_anode), 32'h0);
    checkOutput("rstSeg",      32'(mainIf.io_segOut), 32'h00);
    checkOutput("rstDp",       32'(mainIf.io_dpOut), 32'h0);
    checkOutput("rstPending",  32'(mainIf.io_pending), 32'h0);
    checkOutput("rstInvAnode", 32'(invIf.io_anode), 32'hF);
    checkOutput("rstInvSeg",   32'(invIf.io_segOut), 32'h7F);
    checkOutput("rstInvDp",    32'(invIf.io_dpOut), 32'h1);

    @(negedge clock);
    reset = 1'b0;
    pushFrame(0, 16'h0000, 4'b0000);

    // Plain load: pending until the first frame end, then 1234 is scanned.
    waitCycle(2);
    invIf.io_value = 16'h0008;
    invIf.io_dp    = 4'b0000;
    invIf.io_load  = 1'b1;
    applyStimulus(16'h1234, 4'b0000);
    invIf.io_load  = 1'b0;
    pushFrame(1, 16'h1234, 4'b0000);
    checkOutput("loadPending", 32'(mainIf.io_pending), 32'h1);
    waitCycle(15);
    checkOutput("pendingHeld", 32'(mainIf.io_pending), 32'h1);
    waitCycle(16);
    checkOutput("pendingClear", 32'(mainIf.io_pending), 32'h0);

    // Active-low instance showing 8 on digit 0, then disabled.
    waitCycle(18);
    checkOutput("invAnode", 32'(invIf.io_anode), 32'hE);
    checkOutput("invSeg",   32'(invIf.io_segOut), 32'h00);
    checkOutput("invDp",    32'(invIf.io_dpOut), 32'h1);
    invIf.io_enable = 1'b0;
    waitCycle(19);
    checkOutput("invDisabled", 32'(invIf.io_anode), 32'hF);

    // Leading-zero blanking with a decimal point kept on a blanked digit.
    waitCycle(20);
    applyStimulus(16'h0070, 4'b0100);
    pushFrame(2, 16'h0070, 4'b0100);
    pushFrame(3, 16'h0070, 4'b0100);
    waitCycle(22);
    checkOutput("invBlankSeg", 32'(invIf.io_segOut), 32'h7F);

    // Two loads in one frame: only the last is ever displayed.
    waitCycle(50);
    applyStimulus(16'hAAAA, 4'b0000);
    waitCycle(55);
    applyStimulus(16'h5555, 4'b0000);
    pushFrame(4, 16'h5555, 4'b0000);

    // Load on the frame-end cycle: the older shadow commits first.
    waitCycle(70);
    applyStimulus(16'h9876, 4'b0000);
    pushFrame(5, 16'h9876, 4'b0000);
    waitCycle(79);
    applyStimulus(16'hFFFF, 4'b0000);
    pushFrame(6, 16'hFFFF, 4'b0000);
    checkOutput("edgeLoadPending", 32'(mainIf.io_pending), 32'h1);
    waitCycle(96);
    checkOutput("edgeLoadCommit", 32'(mainIf.io_pending), 32'h0);

    // Enable low blanks anodes next cycle while segments keep decoding.
    waitCycle(115);
    mainIf.io_enable = 1'b0;
    waitCycle(116);
    checkOutput("disableAnode", 32'(mainIf.io_anode), 32'h0);
    checkOutput("disableSeg",   32'(mainIf.io_segOut), 32'h47);
    mainIf.io_enable = 1'b1;
    applyStimulus(16'h4444, 4'b1111);
    waitCycle(118);
    checkOutput("preRstAnode",   32'(mainIf.io_anode), 32'h2);
    checkOutput("preRstPending", 32'(mainIf.io_pending), 32'h1);
    checkOutput("sbDrainedA",    32'(sbQueue.size()), 32'h0);

    // Asynchronous reset in the middle of a slot, away from any edge.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstAnode",   32'(mainIf.io_anode), 32'h0);
    checkOutput("midRstSeg",     32'(mainIf.io_segOut), 32'h00);
    checkOutput("midRstPending", 32'(mainIf.io_pending), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // The discarded 4444 load must never appear.
    pushFrame(0, 16'h0000, 4'b0000);
    pushFrame(1, 16'h0000, 4'b0000);
    waitCycle(1);
    checkOutput("postRstPending", 32'(mainIf.io_pending), 32'h0);
    waitCycle(34);
    checkOutput("sbDrainedB", 32'(sbQueue.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
